// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode/execute pipeline stages.
// Control bundle fields are packed LSB-first in the order listed below.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    localparam int CTRL_W = 14;

    localparam int CTRL_REGWEN_BIT = 0;
    localparam int CTRL_WBSEL_LSB  = 1;
    localparam int CTRL_WBSEL_MSB  = 2;
    localparam int CTRL_ASEL_BIT   = 3;
    localparam int CTRL_BSEL_BIT   = 4;
    localparam int CTRL_MEMRW_BIT  = 5;
    localparam int CTRL_F3_LSB     = 6;
    localparam int CTRL_F3_MSB     = 8;
    localparam int CTRL_ALUSEL_LSB = 9;
    localparam int CTRL_ALUSEL_MSB = 12;
    localparam int CTRL_PCSEL_BIT  = 13;

    localparam int PC_IDX  = 0;
    localparam int A_IDX   = 1;
    localparam int B_IDX   = 2;
    localparam int IMM_IDX = 3;

endpackage

// File: rtl/id_ex_elastic_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_elastic_reg.sv
// ID/EX elastic pipeline register: main entry drives EX, skid entry absorbs one
// instruction of back-pressure so in_ready depends only on registered state.
module id_ex_elastic_reg #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 4,
    parameter int CTRL_W   = pipe_pkg::CTRL_W,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_DATA*DATA_W-1:0]   in_data,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [3*ADDR_W-1:0]          in_addr,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_DATA*DATA_W-1:0]   out_data,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [3*ADDR_W-1:0]          out_addr,
    output logic [1:0]                   occupancy,
    output logic [CNT_W-1:0]             stall_cnt,
    input  logic                         stall_cnt_clr
);

    import pipe_pkg::*;

    localparam int DW = NUM_DATA * DATA_W;
    localparam int AW = 3 * ADDR_W;

    stage_state_e    state_q, state_d;
    logic [DW-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [AW-1:0]   main_addr_q, main_addr_d;
    logic [DW-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [AW-1:0]   skid_addr_q, skid_addr_d;

    logic acc;
    logic fire;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign acc       = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        main_addr_d = main_addr_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_addr_d = skid_addr_q;

        if (flush) begin
            // Bubble: kill control and addresses; operand data is left as-is.
            state_d     = EMPTY;
            main_ctrl_d = '0;
            main_addr_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        main_addr_d = in_addr;
                    end
                end
                ONE: begin
                    if (acc && fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        main_addr_d = in_addr;
                    end else if (acc) begin
                        state_d     = FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        skid_addr_d = in_addr;
                    end else if (fire) begin
                        state_d     = EMPTY;
                        main_ctrl_d = '0;
                        main_addr_d = '0;
                    end
                end
                FULL: begin
                    if (fire) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        main_addr_d = skid_addr_q;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                    main_addr_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            main_addr_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            main_addr_q <= main_addr_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_addr_q <= skid_addr_d;
        end
    end

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign out_data = main_data_q;
    assign out_ctrl = main_ctrl_q;
    assign out_addr = main_addr_q;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (out_valid && !out_ready),
        .clr     (stall_cnt_clr),
        .count   (stall_cnt)
    );

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Randomised and directed bench for id_ex_elastic_reg against a queue-based model.
module tb_id_ex_elastic_reg;

    localparam int DATA_W = 32;
    localparam int NUM_DATA = 4;
    localparam int CW = 14;
    localparam int ADDR_W = 5;
    localparam int DW = NUM_DATA * DATA_W;
    localparam int AW = 3 * ADDR_W;
    localparam int MAX16 = 65535;
    localparam int MAX2 = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
        logic [AW-1:0] addr;
    } instr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          in_valid;
    logic          in_ready, in_ready_s;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic [AW-1:0] in_addr;
    logic          flush;
    logic          out_valid, out_valid_s;
    logic          out_ready;
    logic [DW-1:0] out_data, out_data_s;
    logic [CW-1:0] out_ctrl, out_ctrl_s;
    logic [AW-1:0] out_addr, out_addr_s;
    logic [1:0]    occupancy, occupancy_s;
    logic [15:0]   stall_cnt;
    logic [1:0]    stall_cnt_s;
    logic          stall_cnt_clr;

    id_ex_elastic_reg #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CTRL_W(CW), .ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_addr(in_addr), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .out_addr(out_addr), .occupancy(occupancy),
        .stall_cnt(stall_cnt), .stall_cnt_clr(stall_cnt_clr)
    );

    id_ex_elastic_reg #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CTRL_W(CW), .ADDR_W(ADDR_W), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_addr(in_addr), .flush(flush),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_ctrl(out_ctrl_s), .out_addr(out_addr_s), .occupancy(occupancy_s),
        .stall_cnt(stall_cnt_s), .stall_cnt_clr(stall_cnt_clr)
    );

    int n_checks = 0;
    int n_err = 0;

    instr_t        mq[$];
    logic [31:0]   fired[$];
    logic [DW-1:0] m_main_data;
    int            m_cnt;
    int            m_cnt2;
    logic          m_acc;
    instr_t        cur;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy,
                         input logic fl, input logic clr);
        cur.data = {$urandom, $urandom, $urandom, pc};
        cur.ctrl = CW'($urandom);
        cur.addr = AW'($urandom);
        in_valid = v;
        in_data = cur.data;
        in_ctrl = cur.ctrl;
        in_addr = cur.addr;
        out_ready = ordy;
        flush = fl;
        stall_cnt_clr = clr;
    endtask

    task automatic check_outputs();
        logic ov;
        ov = (mq.size() != 0);
        check("out_valid", out_valid, ov);
        check("in_ready", in_ready, mq.size() < 2);
        check("occupancy", occupancy, mq.size());
        check("out_data", out_data, ov ? mq[0].data : m_main_data);
        check("out_ctrl", out_ctrl, ov ? mq[0].ctrl : '0);
        check("out_addr", out_addr, ov ? mq[0].addr : '0);
        check("stall_cnt", stall_cnt, m_cnt);
        check("stall_cnt_sat", stall_cnt_s, m_cnt2);
    endtask

    task automatic model_update();
        logic ov, acc, fire;
        ov = (mq.size() != 0);
        acc = in_valid && (mq.size() < 2);
        fire = ov && out_ready;
        m_acc = acc;
        if (stall_cnt_clr) begin
            m_cnt = 0;
            m_cnt2 = 0;
        end else if (ov && !out_ready) begin
            if (m_cnt < MAX16) m_cnt++;
            if (m_cnt2 < MAX2) m_cnt2++;
        end
        if (fire) fired.push_back(mq[0].data[31:0]);
        if (flush) begin
            mq.delete();
        end else begin
            if (fire) void'(mq.pop_front());
            if (acc) mq.push_back(cur);
        end
        if (mq.size() != 0) m_main_data = mq[0].data;
    endtask

    task automatic tick();
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] first_fired;
        int n;

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        mq.delete();
        m_main_data = '0;
        m_cnt = 0;
        m_cnt2 = 0;
        m_acc = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_occupancy", occupancy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_stall_cnt", stall_cnt, 0);

        // Streaming, 8 back-to-back with out_ready held high
        fired.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'(i * 4), 1, 0, 0);
            tick();
            check("stream_occ", occupancy, 1);
        end
        drive(0, 0, 1, 0, 0);
        tick();
        check("stream_count", fired.size(), 8);
        for (int i = 0; i < fired.size(); i++) check("stream_order", fired[i], 32'(i * 4));
        check("stream_stall_cnt", stall_cnt, 0);

        // Back-pressure: out_ready low for three cycles mid-stream
        fired.delete();
        pc = 32'h100;
        for (int k = 0; k < 12; k++) begin
            drive(1, pc, !(k >= 3 && k < 6), 0, 0);
            tick();
            if (m_acc) pc += 4;
            if (k == 3) begin
                check("bp_in_ready_fall", in_ready, 0);
                check("bp_occ_full", occupancy, 2);
            end
            if (k == 5) check("bp_stall_cnt", stall_cnt, 3);
        end
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 1, 0, 0);
            tick();
        end
        check("bp_drained", occupancy, 0);
        check("bp_count", fired.size(), (pc - 32'h100) / 4);
        for (int i = 0; i < fired.size(); i++) check("bp_order", fired[i], 32'h100 + 32'(i * 4));

        // Flush while FULL with a same-cycle input
        fired.delete();
        drive(1, 32'h10, 0, 0, 0); tick();
        drive(1, 32'h14, 0, 0, 0); tick();
        check("fl_full", occupancy, 2);
        drive(1, 32'h18, 0, 1, 0); tick();
        check("fl_out_valid", out_valid, 0);
        check("fl_out_ctrl", out_ctrl, 0);
        check("fl_occupancy", occupancy, 0);
        check("fl_in_ready", in_ready, 1);
        drive(0, 0, 1, 0, 0); tick();
        drive(0, 0, 1, 0, 0); tick();
        check("fl_nothing_fired", fired.size(), 0);

        // Flush with same-cycle fire
        fired.delete();
        drive(1, 32'h20, 0, 0, 0); tick();
        drive(0, 0, 1, 1, 0); tick();
        first_fired = (fired.size() != 0) ? fired[0] : 32'hdead_beef;
        check("flfire_count", fired.size(), 1);
        check("flfire_pc", first_fired, 32'h20);
        check("flfire_empty", occupancy, 0);

        // Saturation on the 2-bit counter, then clear priority
        drive(1, 32'h30, 0, 0, 1); tick();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 0);
            tick();
        end
        check("sat_cnt2", stall_cnt_s, 3);
        check("sat_cnt16", stall_cnt, 5);
        drive(0, 0, 0, 0, 1); tick();
        check("sat_clr2", stall_cnt_s, 0);
        check("sat_clr16", stall_cnt, 0);

        // Asynchronous reset mid-cycle while FULL
        drive(1, 32'h34, 0, 0, 0); tick();
        check("ar_full", occupancy, 2);
        drive(0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_in_ready", in_ready, 1);
        check("ar_occupancy", occupancy, 0);
        check("ar_out_data", out_data, 0);
        check("ar_out_ctrl", out_ctrl, 0);
        check("ar_out_addr", out_addr, 0);
        check("ar_stall_cnt", stall_cnt, 0);
        mq.delete();
        m_main_data = '0;
        m_cnt = 0;
        m_cnt2 = 0;
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic
        pc = 32'h1000;
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 4) != 0, pc, ($urandom % 3) != 0,
                  ($urandom % 23) == 0, ($urandom % 31) == 0);
            tick();
            if (m_acc) pc += 4;
        end
        n = 0;
        while (mq.size() != 0 && n < 8) begin
            drive(0, 0, 1, 0, 0);
            tick();
            n++;
        end
        check("final_drained", occupancy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_elastic_reg.md
# id_ex_elastic_reg

Parametrised ID/EX pipeline register with a valid/ready handshake, a 2-entry skid buffer, a flush (bubble) input and a saturating stall counter. It sits between decode and execute. It generalises the fixed-width, always-advancing ID/EX latch to configurable operand count and width. It supports back-pressure from EX and kills the wrong-path instruction on branch or jump.

## Interface
Parameters:
- DATA_W, 32, width of each datapath operand.
- NUM_DATA, 4, operand count. Packed LSB-first as PC, DataA, DataB, Imm.
- CTRL_W, 14, packed control width: RegWEn, WBSel[1:0], DataASel, DataBSel, MemRW, funct3[2:0], ALUSel[3:0], PCSel.
- ADDR_W, 5, register address width. Three addresses are carried: AddrD, AddrA, AddrB.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept. Equals (state != FULL).
- in_data  in  NUM_DATA*DATA_W  operands.
- in_ctrl  in  CTRL_W  control bundle.
- in_addr  in  3*ADDR_W  {AddrB, AddrA, AddrD}.
- flush  in  1  kill all held and incoming instructions.
- out_valid  out  1  main entry holds a live instruction.
- out_ready  in  1  EX consumes the instruction.
- out_data  out  NUM_DATA*DATA_W  main entry operands.
- out_ctrl  out  CTRL_W  main entry control.
- out_addr  out  3*ADDR_W  main entry addresses.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready.
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Handshake events:
  - acc = in_valid && in_ready.
  - fire = out_valid && out_ready.
- Storage: main entry drives the outputs directly. Skid entry holds one overflow instruction.
- State machine {EMPTY, ONE, FULL}, evaluated with flush=0:
  - EMPTY: acc -> ONE, main <= input.
  - ONE, acc && fire: stay ONE, main <= input.
  - ONE, acc && !fire: -> FULL, skid <= input.
  - ONE, !acc && fire: -> EMPTY.
  - FULL (in_ready=0), fire: -> ONE, main <= skid.
  - FULL, !fire: hold.
- flush=1: next state is EMPTY from any state.
  - A same-cycle input is discarded and never appears at the output.
  - A same-cycle fire is still a valid consumption by EX.
- Bubble masking: every transition into EMPTY (drain, flush, reset) clears main ctrl and main addr to 0, so RegWEn and MemRW are 0 in bubbles. Main data is retained on drain and flush, and is zeroed only by reset.
- out_valid = (state != EMPTY). occupancy is 0, 1 or 2 for EMPTY, ONE or FULL.
- Output stability: while out_valid && !out_ready, out_data, out_ctrl and out_addr do not change (unless flush).
- Stall counter:
  - +1 per cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1.
  - stall_cnt_clr has priority over increment.
  - Not affected by flush.

## Timing
- Latency: 1 cycle from acc (EMPTY or ONE with fire) to out_valid. An instruction that goes through the skid appears at the output 1 cycle after the fire that frees main.
- Throughput: 1 instruction per cycle when out_ready is held at 1.
- in_ready depends only on registered state, with no combinational path from out_ready. Upstream may assert in_valid in the cycle in_ready first rises.
- Reset, asynchronous: state EMPTY, all entries 0, stall_cnt 0. This gives out_valid=0, in_ready=1, occupancy=0, and all outputs 0.
- Reset mid-operation drops both entries immediately. No instruction is replayed.

## Structure
- Shared package pipe_pkg holds:
  - the stage_state_e enum {EMPTY, ONE, FULL};
  - CTRL_W and per-field bit offsets for the control bundle;
  - the operand index constants PC_IDX, A_IDX, B_IDX, IMM_IDX.
- One sub-module: sat_counter (parameter W; inputs inc and clr). It implements stall_cnt.
- Main and skid entries are inline registers. No FIFO sub-module.

## Test plan
- Streaming: 8 back-to-back instructions, PC = 0x00, 0x04, … 0x1C, with out_ready=1 -> same order on the output, each 1 cycle later. occupancy stays 1 and stall_cnt = 0.
- Back-pressure: out_ready=0 for 3 cycles during streaming -> in_ready falls 1 cycle after the stall begins and occupancy reaches 2. After release, PCs are in order with none lost or duplicated. stall_cnt = 3.
- Flush in FULL: main holds PC 0x10, skid holds 0x14, in_valid carries 0x18, flush=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0. 0x10, 0x14 and 0x18 never fire.
- Flush with same-cycle fire: PC 0x20 fires while flush=1 -> 0x20 counts as consumed and the stage is empty next cycle.
- Async reset: assert reset_n low mid-cycle while FULL -> all outputs 0 immediately and in_ready=1. With CNT_W=2, after 5 stall cycles stall_cnt saturates at 3, and stall_cnt_clr returns it to 0.
